rx_drain_ctrl: RTL and testbench

//  Sequences readout of the receive RAM once a frame has landed. Started by the frame-complete pulse

---
 rtl/rx_pkg.sv | 14 +
 rtl/rx_skid2.sv | 47 ++++
 rtl/rx_drain_ctrl.sv | 123 ++++++++++++
 tb/tb_rx_drain_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_pkg.sv
// Shared receive-path types: drain sequencer state encoding and default widths.
package rx_pkg;

  localparam int RX_DATA_WIDTH = 8;
  localparam int RX_ADDR_WIDTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2,
    CSUM  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/rx_skid2.sv
// Two-entry skid buffer. An empty buffer passes push_data straight to head, and a
// simultaneous push and pop then leaves it empty.
module rx_skid2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] head
);

  logic [W-1:0] mem [2];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count_q;
  logic         bypass;

  assign count  = count_q;
  assign valid  = (count_q != 2'd0) || push;
  assign head   = (count_q != 2'd0) ? mem[rd_ptr] : push_data;
  assign bypass = (count_q == 2'd0) && push && pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= 1'b0;
      rd_ptr  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (push && !bypass) wr_ptr <= ~wr_ptr;
      if (pop && !bypass)  rd_ptr <= ~rd_ptr;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  // Storage carries no reset; occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push && !bypass) mem[wr_ptr] <= push_data;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count_q == 2'd2));

endmodule

// File: rtl/rx_drain_ctrl.sv
// Receive RAM drain sequencer: reads a landed frame and streams it over valid/ready.
// Optional trailing XOR checksum beat when RX_DRAIN_CSUM_EN is defined.
// out_valid/out_ready: a beat transfers on a rising clk edge where both are high;
// once out_valid rises, it and out_data/out_last hold until that transfer.
module rx_drain_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_WIDTH = RX_DATA_WIDTH,
  parameter int ADDR_WIDTH = RX_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_done,
  output logic                  ram_re,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  rx_hold,
  output logic                  drain_done,
  output logic                  overrun,
  output drain_state_e          dbg_state
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  drain_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [ADDR_WIDTH-1:0] beat_cnt;
  logic                  inflight;
  logic                  overrun_q;
  logic [1:0]            skid_count;
  logic                  skid_valid;
  logic [DATA_WIDTH-1:0] skid_head;
  logic                  skid_pop;
  logic [2:0]            occ_after;
  logic                  drained;

  rx_skid2 #(.W(DATA_WIDTH)) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (ram_q),
    .pop       (skid_pop),
    .count     (skid_count),
    .valid     (skid_valid),
    .head      (skid_head)
  );

  assign skid_pop = skid_valid && out_ready;
  // Credit counts the slot freed by a same-cycle pop so streaming sustains 1 byte/cycle.
  assign occ_after = {1'b0, skid_count} + {2'b00, inflight} - {2'b00, skid_pop};
  assign ram_re    = (state == READ) && (occ_after < 3'd2);
  assign ram_addr  = rd_ptr;
  assign drained   = (skid_count == 2'd0) && !inflight;
  assign rx_hold   = (state != IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (frame_done) state_nxt = READ;
      READ:  if (ram_re && rd_ptr == LAST_ADDR) state_nxt = FLUSH;
`ifdef RX_DRAIN_CSUM_EN
      FLUSH: if (drained) state_nxt = CSUM;
      CSUM:  if (out_ready) state_nxt = IDLE;
`else
      FLUSH: if (drained) state_nxt = IDLE;
      CSUM:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rd_ptr    <= '0;
      beat_cnt  <= '0;
      inflight  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= ram_re;
      if (ram_re) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      if (state == IDLE && frame_done) beat_cnt <= '0;
      else if (skid_pop)               beat_cnt <= beat_cnt + ADDR_WIDTH'(1);
      if (frame_done && state != IDLE) overrun_q <= 1'b1;
    end
  end

`ifdef RX_DRAIN_CSUM_EN
  logic [DATA_WIDTH-1:0] csum_q;
  logic                  drain_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      csum_q       <= '0;
      drain_done_q <= 1'b0;
    end else begin
      if (state == IDLE && frame_done) csum_q <= '0;
      else if (skid_pop)               csum_q <= csum_q ^ skid_head;
      drain_done_q <= (state == CSUM) && out_ready;
    end
  end

  assign out_valid  = skid_valid || (state == CSUM);
  assign out_data   = (state == CSUM) ? csum_q : skid_head;
  assign out_last   = (state == CSUM);
  assign drain_done = drain_done_q;
`else
  assign out_valid  = skid_valid;
  assign out_data   = skid_head;
  assign out_last   = skid_valid && (beat_cnt == LAST_ADDR);
  // Last beat empties the pipe, so "drained in FLUSH" is exactly the cycle after it.
  assign drain_done = (state == FLUSH) && drained;
`endif

endmodule

// File: tb/tb_rx_drain_ctrl.sv
// Randomized scoreboard bench for rx_drain_ctrl (honours RX_DRAIN_CSUM_EN if defined).
module tb_rx_drain_ctrl;
  import rx_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_done = 1'b0;
  logic          ram_re;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_q = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          rx_hold;
  logic          drain_done;
  logic          overrun;
  drain_state_e  dbg_state;

  rx_drain_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_done(frame_done),
    .ram_re(ram_re), .ram_addr(ram_addr), .ram_q(ram_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .rx_hold(rx_hold), .drain_done(drain_done),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM model and ready driver ----------------
  logic [DW-1:0] ram_mem [DEPTH];
  int            ready_mode = 0;   // 0 always, 1 pattern 1,0,0, 2 random, 3 stuck low

  initial begin
    logic          pend;
    logic [AW-1:0] paddr;
    forever begin
      @(negedge clk);
      pend  = ram_re;
      paddr = ram_addr;
      @(posedge clk);
      #1;
      ram_q = pend ? ram_mem[paddr] : DW'($urandom);
    end
  end

  initial begin
    int ph = 0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = (ph % 3 == 0);
        2:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = 1'b0;
      endcase
      ph++;
    end
  end

  // ---------------- scoreboard / reference model ----------------
  logic [DW:0]   exp_q[$];         // {last, data}
  logic          hold_m = 1'b0;    // model values for the current cycle
  logic          done_m = 1'b0;
  logic          ovr_m  = 1'b0;
  int            cyc = 0;
  int            issued = 0, accepted = 0, issue_idx = 0;
  int            start_cyc = 0, due_cyc = -1, beats_in_frame = 0, frames_out = 0;
  logic          all_ready_frame = 1'b0;
  logic          stall_prev = 1'b0;
  logic [DW:0]   stall_beat = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("reset_outputs", {26'd0, ram_re, out_valid, out_last, rx_hold, drain_done, overrun}, 32'd0);
        chk("reset_state", {30'd0, dbg_state}, {30'd0, IDLE});
        exp_q.delete();
        hold_m = 1'b0; done_m = 1'b0; ovr_m = 1'b0;
        issued = 0; accepted = 0; issue_idx = 0; due_cyc = -1;
        beats_in_frame = 0; stall_prev = 1'b0;
      end else begin
        logic        acc, done_next, hold_next;
        logic [DW:0] e;
        acc       = out_valid && out_ready;
        done_next = 1'b0;
        chk("rx_hold", {31'd0, rx_hold}, {31'd0, hold_m});
        chk("drain_done", {31'd0, drain_done}, {31'd0, done_m});
        chk("overrun", {31'd0, overrun}, {31'd0, ovr_m});
        if (due_cyc == cyc) chk("first_latency", {31'd0, out_valid}, 32'd1);
        if (stall_prev) begin
          chk("stall_valid", {31'd0, out_valid}, 32'd1);
          chk("stall_beat", {23'd0, out_last, out_data}, {23'd0, stall_beat});
        end
        if (ram_re) begin
          chk("ram_addr", {30'd0, ram_addr}, issue_idx);
          chk("read_credit", {31'd0, (issued - accepted - int'(acc)) < 2}, 32'd1);
          issued++;
          issue_idx = (issue_idx + 1) % DEPTH;
        end
        if (acc) begin
          if (exp_q.size() == 0) begin
            chk("spurious_beat", {23'd0, out_last, out_data}, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            chk("beat", {23'd0, out_last, out_data}, {23'd0, e});
            accepted++;
            beats_in_frame++;
            if (e[DW]) begin
              done_next = 1'b1;
              frames_out++;
`ifndef RX_DRAIN_CSUM_EN
              if (all_ready_frame) chk("throughput", cyc, start_cyc + 1 + DEPTH);
`endif
            end
          end
        end
        stall_prev = out_valid && !out_ready;
        stall_beat = {out_last, out_data};
        if (frame_done && !hold_m) begin
          logic [DW-1:0] x;
          x = '0;
          for (int i = 0; i < DEPTH; i++) begin
`ifdef RX_DRAIN_CSUM_EN
            exp_q.push_back({1'b0, ram_mem[i]});
            x = x ^ ram_mem[i];
`else
            exp_q.push_back({(i == DEPTH - 1), ram_mem[i]});
`endif
          end
`ifdef RX_DRAIN_CSUM_EN
          exp_q.push_back({1'b1, x});
`endif
          hold_next       = 1'b1;
          start_cyc       = cyc;
          due_cyc         = cyc + 2;
          all_ready_frame = (ready_mode == 0);
          beats_in_frame  = 0;
        end else begin
`ifdef RX_DRAIN_CSUM_EN
          hold_next = done_next ? 1'b0 : hold_m;
`else
          hold_next = done_m ? 1'b0 : hold_m;
`endif
        end
        ovr_m  = ovr_m | (frame_done && hold_m);
        done_m = done_next;
        hold_m = hold_next;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic load_ram(input logic [DW-1:0] d0, d1, d2, d3);
    ram_mem[0] = d0; ram_mem[1] = d1; ram_mem[2] = d2; ram_mem[3] = d3;
  endtask

  task automatic pulse_frame();
    @(posedge clk); #1; frame_done = 1'b1;
    @(posedge clk); #1; frame_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (!(hold_m == 1'b0 && done_m == 1'b0 && exp_q.size() == 0) && n < 400);
    if (n >= 400) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_last_accept(input string name);
    int n = 0;
    int f0 = frames_out;
    do begin
      @(negedge clk); #1; n++;
    end while (frames_out == f0 && n < 400);
    if (n >= 400) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic wait_beats(input int k, input string name);
    int n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while (beats_in_frame < k && n < 400);
    if (n >= 400) chk({name, "_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    load_ram(8'h11, 8'h22, 8'h33, 8'h44);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    // directed frame, ready held high
    ready_mode = 0;
    pulse_frame();
    wait_idle("t1");

    // stalls: 1,0,0 pattern, then a long stuck-low window
    load_ram(8'hA5, 8'h5A, 8'hC3, 8'h3C);
    ready_mode = 1;
    pulse_frame();
    wait_idle("t2a");
    load_ram(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
    ready_mode = 3;
    pulse_frame();
    repeat (25) @(posedge clk);
    ready_mode = 0;
    wait_idle("t2b");

    // second frame_done mid-drain, then one in the drain_done cycle
    load_ram(8'h10, 8'h20, 8'h30, 8'h40);
    ready_mode = 1;
    pulse_frame();
    repeat (3) @(posedge clk);
    #1; frame_done = 1'b1;
    @(posedge clk); #1; frame_done = 1'b0;
    wait_last_accept("t3a");
    pulse_frame();   // lands in the drain_done cycle
    wait_idle("t3b");
    ready_mode = 0;
    pulse_frame();
    wait_idle("t3c");

    // reset after the second beat, then a fresh frame from address 0
    load_ram(8'h01, 8'h02, 8'h04, 8'h08);
    ready_mode = 0;
    pulse_frame();
    wait_beats(2, "t4");
    #1; rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1;
    pulse_frame();
    wait_idle("t4b");

    // back-to-back: new frame_done the cycle after drain_done
    load_ram(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    pulse_frame();
    wait_last_accept("t6a");
    @(posedge clk);
    pulse_frame();
    wait_idle("t6b");

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      load_ram(DW'($urandom), DW'($urandom), DW'($urandom), DW'($urandom));
      ready_mode = $urandom_range(0, 2);
      pulse_frame();
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 4)) @(posedge clk);
        #1; frame_done = 1'b1;
        @(posedge clk); #1; frame_done = 1'b0;
      end
      wait_idle("rand");
      if (f == 15) do_reset();
    end

    repeat (4) @(posedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
